// File: rtl/display_pkg.sv
// Shared types and constants for the BCD seven-segment display stage.
package display_pkg;

    localparam int DISP_DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } disp_state_t;

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder with blank override.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Non-decimal codes cannot come out of the converter; show them blank.
    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    seg_o = SEG_DIGIT[0];
                4'd1:    seg_o = SEG_DIGIT[1];
                4'd2:    seg_o = SEG_DIGIT[2];
                4'd3:    seg_o = SEG_DIGIT[3];
                4'd4:    seg_o = SEG_DIGIT[4];
                4'd5:    seg_o = SEG_DIGIT[5];
                4'd6:    seg_o = SEG_DIGIT[6];
                4'd7:    seg_o = SEG_DIGIT[7];
                4'd8:    seg_o = SEG_DIGIT[8];
                4'd9:    seg_o = SEG_DIGIT[9];
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/count_bcd_display.sv
// Watches the binary count, converts each new value to BCD with a
// one-shift-per-clock double-dabble, and drives four active-low 7-seg digits.
// The four hex ports are fixed, so DIGITS must stay at 4.
module count_bcd_display
    import display_pkg::*;
#(
    parameter int WIDTH         = 11,
    parameter int DIGITS        = DISP_DIGITS,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      count,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [6:0]            hex0,
    output logic [6:0]            hex1,
    output logic [6:0]            hex2,
    output logic [6:0]            hex3,
    output logic                  busy,
    output logic                  done
);

    localparam int ITER_W = $clog2(WIDTH);
    localparam int BCD_W  = 4 * DIGITS;

    disp_state_t                  state_q, state_d;
    logic [WIDTH-1:0]             bin_q,   bin_d;    // binary shift register
    logic [WIDTH-1:0]             val_q,   val_d;    // value under conversion
    logic [WIDTH-1:0]             last_q,  last_d;   // last value displayed
    logic [BCD_W-1:0]             work_q,  work_d;   // BCD work register
    logic [ITER_W-1:0]            iter_q,  iter_d;
    logic [BCD_W-1:0]             bcd_q,   bcd_d;
    logic [DIGITS-1:0][6:0]       hex_q,   hex_d;
    logic                         busy_q,  busy_d;
    logic                         done_q,  done_d;

    logic [BCD_W-1:0]             adj;
    logic [DIGITS-1:0]            blank;
    logic [DIGITS-1:0][6:0]       seg_dec;

    // Add-3 correction on every digit >= 5 before the shift; max result 12, no carry.
    always_comb begin
        adj = work_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
        end
    end

    // Leading-zero chain: a digit blanks only if it and all higher digits are zero.
    always_comb begin
        logic lead;
        lead  = (BLANK_LEADING != 0);
        blank = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead     = lead && (work_q[4*i +: 4] == 4'd0);
            blank[i] = lead;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        seg7_decode u_seg (
            .digit_i (work_q[4*g +: 4]),
            .blank_i (blank[g]),
            .seg_o   (seg_dec[g])
        );
    end

    // Conversion FSM and datapath next-state.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        val_d   = val_q;
        last_d  = last_q;
        work_d  = work_q;
        iter_d  = iter_q;
        bcd_d   = bcd_q;
        hex_d   = hex_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != last_q) begin
                    bin_d   = count;
                    val_d   = count;
                    work_d  = '0;
                    iter_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d = {adj[BCD_W-2:0], bin_q[WIDTH-1]};
                bin_d  = {bin_q[WIDTH-2:0], 1'b0};
                iter_d = iter_q + 1'b1;
                if (iter_q == ITER_W'(WIDTH - 1))
                    state_d = DONE;
            end
            DONE: begin
                bcd_d   = work_q;
                hex_d   = seg_dec;
                last_d  = val_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            val_q   <= '0;
            last_q  <= '0;
            work_q  <= '0;
            iter_q  <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < DIGITS; i++)
                hex_q[i] <= (i == 0 || BLANK_LEADING == 0) ? SEG_DIGIT[0] : SEG_BLANK;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            val_q   <= val_d;
            last_q  <= last_d;
            work_q  <= work_d;
            iter_q  <= iter_d;
            bcd_q   <= bcd_d;
            hex_q   <= hex_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bcd  = bcd_q;
    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_count_bcd_display.sv
// Bench for count_bcd_display: two instances (leading blanking on/off) driven
// in lockstep, checked against an arithmetic decimal/segment model.
module tb_count_bcd_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] count;

    logic [15:0] bcd_a, bcd_b;
    logic [6:0]  h0a, h1a, h2a, h3a, h0b, h1b, h2b, h3b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [6:0]  hxa [4];
    logic [6:0]  hxb [4];

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 clk = ~clk;

    count_bcd_display #(.WIDTH(11), .DIGITS(4), .BLANK_LEADING(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .count(count), .bcd(bcd_a),
        .hex0(h0a), .hex1(h1a), .hex2(h2a), .hex3(h3a),
        .busy(busy_a), .done(done_a)
    );

    count_bcd_display #(.WIDTH(11), .DIGITS(4), .BLANK_LEADING(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .count(count), .bcd(bcd_b),
        .hex0(h0b), .hex1(h1b), .hex2(h2b), .hex3(h3b),
        .busy(busy_b), .done(done_b)
    );

    assign hxa[0] = h0a; assign hxa[1] = h1a; assign hxa[2] = h2a; assign hxa[3] = h3a;
    assign hxb[0] = h0b; assign hxb[1] = h1b; assign hxb[2] = h2b; assign hxb[3] = h3b;

    // Decimal digits of v packed four bits each.
    function automatic logic [15:0] model_bcd(int v);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Digit d of v is blank when blanking is on, d > 0 and v has fewer than d+1 digits.
    function automatic logic [6:0] model_seg(int v, int d, bit blank_en);
        int p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        if (blank_en && d > 0 && v < p) return 7'h7F;
        return seg_tab[(v / p) % 10];
    endfunction

    // Counts falling edges until done is seen; 999 on timeout.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done_a && cyc < 100);
        if (!done_a) cyc = 999;
    endtask

    task automatic test_reset();
        int cyc;
        rst_n = 1'b0;
        count = 11'd5;
        repeat (2) @(negedge clk);
        checks++; if (bcd_a !== 16'h0) begin errors++; $display("FAIL reset_bcd: got %h expected 0000", bcd_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_a); end
        checks++; if (hxa[0] !== 7'h40) begin errors++; $display("FAIL reset_hex0: got %h expected 40", hxa[0]); end
        for (int d = 1; d < 4; d++) begin
            checks++; if (hxa[d] !== 7'h7F) begin errors++; $display("FAIL reset_hexA%0d: got %h expected 7f", d, hxa[d]); end
            checks++; if (hxb[d] !== 7'h40) begin errors++; $display("FAIL reset_hexB%0d: got %h expected 40", d, hxb[d]); end
        end
        rst_n = 1'b1;
        wait_done(cyc);
        checks++; if (cyc != 13) begin errors++; $display("FAIL reset5_latency: got %0d expected 13", cyc); end
        checks++; if (bcd_a !== 16'h0005) begin errors++; $display("FAIL reset5_bcd: got %h expected 0005", bcd_a); end
        checks++; if (hxa[0] !== 7'h12) begin errors++; $display("FAIL reset5_hex0: got %h expected 12", hxa[0]); end
    endtask

    task automatic test_hold_1234();
        int cyc;
        int extra;
        count = 11'd1234;
        @(negedge clk);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL 1234_busy: got %b expected 1", busy_a); end
        wait_done(cyc);
        checks++; if (cyc + 1 != 13) begin errors++; $display("FAIL 1234_latency: got %0d expected 13", cyc + 1); end
        checks++; if (bcd_a !== 16'h1234) begin errors++; $display("FAIL 1234_bcd: got %h expected 1234", bcd_a); end
        checks++; if (hxa[3] !== 7'h79) begin errors++; $display("FAIL 1234_hex3: got %h expected 79", hxa[3]); end
        checks++; if (hxa[2] !== 7'h24) begin errors++; $display("FAIL 1234_hex2: got %h expected 24", hxa[2]); end
        checks++; if (hxa[1] !== 7'h30) begin errors++; $display("FAIL 1234_hex1: got %h expected 30", hxa[1]); end
        checks++; if (hxa[0] !== 7'h19) begin errors++; $display("FAIL 1234_hex0: got %h expected 19", hxa[0]); end
        extra = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done_a) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL 1234_no_repeat: got %0d pulses expected 0", extra); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL 1234_idle_busy: got %b expected 0", busy_a); end
    endtask

    task automatic test_values();
        int vals [4] = '{2047, 7, 0, 1009};
        int cyc;
        for (int k = 0; k < 4; k++) begin
            count = 11'(vals[k]);
            wait_done(cyc);
            checks++; if (cyc != 13) begin errors++; $display("FAIL val%0d_latency: got %0d expected 13", vals[k], cyc); end
            checks++; if (bcd_a !== model_bcd(vals[k])) begin errors++; $display("FAIL val%0d_bcd: got %h expected %h", vals[k], bcd_a, model_bcd(vals[k])); end
            for (int d = 0; d < 4; d++) begin
                checks++; if (hxa[d] !== model_seg(vals[k], d, 1)) begin errors++; $display("FAIL val%0d_hexA%0d: got %h expected %h", vals[k], d, hxa[d], model_seg(vals[k], d, 1)); end
                checks++; if (hxb[d] !== model_seg(vals[k], d, 0)) begin errors++; $display("FAIL val%0d_hexB%0d: got %h expected %h", vals[k], d, hxb[d], model_seg(vals[k], d, 0)); end
            end
        end
    endtask

    task automatic test_change_mid();
        int ndone = 0;
        int t1 = 0, t2 = 0;
        logic [15:0] b1 = '0, b2 = '0;
        count = 11'd100;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done_a) begin
                ndone++;
                if (ndone == 1) begin t1 = n; b1 = bcd_a; end
                if (ndone == 2) begin t2 = n; b2 = bcd_a; end
            end
            if (n == 5) count = 11'd200;
        end
        checks++; if (ndone != 2) begin errors++; $display("FAIL mid_pulses: got %0d expected 2", ndone); end
        checks++; if (t1 != 13) begin errors++; $display("FAIL mid_t1: got %0d expected 13", t1); end
        checks++; if (b1 !== 16'h0100) begin errors++; $display("FAIL mid_b1: got %h expected 0100", b1); end
        checks++; if (t2 != 26) begin errors++; $display("FAIL mid_t2: got %0d expected 26", t2); end
        checks++; if (b2 !== 16'h0200) begin errors++; $display("FAIL mid_b2: got %h expected 0200", b2); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int early = 0;
        count = 11'd300;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (done_a) early++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (early != 0 || done_a !== 1'b0) begin errors++; $display("FAIL rmid_done: got %0d/%b expected 0/0", early, done_a); end
        checks++; if (bcd_a !== 16'h0) begin errors++; $display("FAIL rmid_bcd: got %h expected 0000", bcd_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy_a); end
        checks++; if (hxa[0] !== 7'h40 || hxa[3] !== 7'h7F) begin errors++; $display("FAIL rmid_hex: got %h/%h expected 40/7f", hxa[0], hxa[3]); end
        rst_n = 1'b1;
        wait_done(cyc);
        checks++; if (cyc != 13) begin errors++; $display("FAIL rmid_latency: got %0d expected 13", cyc); end
        checks++; if (bcd_a !== 16'h0300) begin errors++; $display("FAIL rmid_bcd300: got %h expected 0300", bcd_a); end
    endtask

    task automatic test_random();
        int v, prev, cyc;
        prev = 300;
        for (int k = 0; k < 24; k++) begin
            v = int'($urandom_range(0, 2047));
            if (v == prev) v = (v + 1) % 2048;
            count = 11'(v);
            wait_done(cyc);
            checks++; if (cyc != 13) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected 13", v, cyc); end
            checks++; if (bcd_a !== model_bcd(v) || bcd_b !== model_bcd(v)) begin errors++; $display("FAIL rnd%0d_bcd: got %h/%h expected %h", v, bcd_a, bcd_b, model_bcd(v)); end
            for (int d = 0; d < 4; d++) begin
                checks++; if (hxa[d] !== model_seg(v, d, 1)) begin errors++; $display("FAIL rnd%0d_hexA%0d: got %h expected %h", v, d, hxa[d], model_seg(v, d, 1)); end
                checks++; if (hxb[d] !== model_seg(v, d, 0)) begin errors++; $display("FAIL rnd%0d_hexB%0d: got %h expected %h", v, d, hxb[d], model_seg(v, d, 0)); end
            end
            prev = v;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_hold_1234();
        test_values();
        test_change_mid();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
